layer_frame_sched: RTL and testbench
====================================

Name: layer_frame_sched

Overview:
- Frame scheduler in front of the per-layer LED output channels.
- Accepts the host byte stream for one full cube frame and distributes each byte as a write strobe to the correct layer, LED address and colour byte lane.
- Once a frame is complete, it issues a single frame_rdy pulse to all layers, while enforcing a minimum latch gap between pulses.

Parameters:
- LAYER_CNT, 8, number of layers; width of the one-hot write enable.
- LED_CNT, 64, LEDs per layer; must be ≤ 64 so the address fits in wr_addr.
- BYTES_PER_LED, 3, colour bytes per LED; legal values 3 or 4.
- MIN_FRAME_GAP, 15000, minimum clk cycles between two frame_rdy pulses (LED latch time).
- REFRESH_PERIOD, 2500000, auto-refresh interval in cycles; used only with AUTO_REFRESH_EN.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- frame_start_in  in  1  one-cycle pulse that starts frame loading.
- data_valid_in  in  1  host byte valid.
- data_in  in  8  host byte.
- data_rdy_out  out  1  byte accepted when data_valid_in && data_rdy_out.
- layer_en_out  out  LAYER_CNT  one-hot write enable for the target layer; all zero when no write.
- wr_addr_out  out  6  LED index within the layer.
- byte_sel_out  out  4  one-hot colour byte lane.
- byte_data_out  out  8  byte to write.
- frame_rdy_out  out  1  one-cycle pulse telling all layers to refresh.
- busy_out  out  1  high in any state other than IDLE.
- abort_err_out  out  1  sticky flag: a frame was restarted mid-load.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; gap timer preset to MIN_FRAME_GAP (saturated) so the first frame fires without waiting.
- States:
  - IDLE: data_rdy_out=0. On frame_start_in → LOAD, clearing the byte, LED and layer counters.
  - LOAD: data_rdy_out=1.
    - Each accepted byte produces, on the next cycle, a one-cycle strobe (write latency 1):
      - layer_en_out = 1<<layer;
      - wr_addr_out = led;
      - byte_sel_out = 1<<byte_idx;
      - byte_data_out = data_in.
    - Address and data outputs hold their last value between strobes.
    - Counter order: byte_idx increments first and wraps at BYTES_PER_LED; then led increments and wraps at LED_CNT; then layer increments.
    - Accepting the byte with layer=LAYER_CNT-1, led=LED_CNT-1, byte_idx=BYTES_PER_LED-1 → WAIT_GAP. data_rdy_out drops in the same cycle as the transition, so no extra byte is accepted.
  - WAIT_GAP: data_rdy_out=0. When gap_timer ≥ MIN_FRAME_GAP → FIRE. Never waits if the gap has already elapsed; the minimum time spent here is 1 cycle.
  - FIRE: frame_rdy_out=1 for exactly one cycle; gap_timer cleared to 0. Next state is LOAD if a start is pending (clear counters and the pending flag), otherwise IDLE.
- Gap timer: 16-bit; increments every cycle; saturates at MIN_FRAME_GAP; never wraps.
- frame_start_in while in LOAD:
  - Counters reset and the state stays LOAD.
  - A byte handshaken in the same cycle is discarded; no strobe is generated for it.
  - abort_err_out is set if at least one byte of the current frame had been accepted.
- frame_start_in while in WAIT_GAP or FIRE: latched as pending and serviced after FIRE. Multiple starts collapse into one.
- frame_start_in and data_valid_in together in IDLE: the start is taken; the byte is not accepted because data_rdy_out=0.
- abort_err_out is cleared only by rst_in.
- Reset mid-operation: everything returns to reset values immediately. Any in-flight write strobe is suppressed.

Optional Feature:
- Macro: LAYER_FRAME_SCHED_AUTO_REFRESH_EN.
- Defined:
  - While in IDLE, a refresh counter counts cycles since the last frame_rdy.
  - On reaching REFRESH_PERIOD, the block goes to WAIT_GAP → FIRE and re-issues frame_rdy_out with the stored frame; no writes occur.
  - frame_start_in arriving at the same moment takes priority.
- Undefined: frame_rdy_out pulses only after a fully loaded frame; the refresh counter and REFRESH_PERIOD logic are absent.

Test Plan:
All scenarios use LAYER_CNT=2, LED_CNT=4, BYTES_PER_LED=3, MIN_FRAME_GAP=20, REFRESH_PERIOD=100.
- Full frame, after reset:
  - Stimulus: start, then 24 back-to-back bytes 0x00..0x17.
  - Strobes: 24 strobes. Byte 0x05 → layer_en=01, addr=1, byte_sel=0100. Byte 0x0C → layer_en=10, addr=0, byte_sel=0001.
  - Timing: frame_rdy pulses exactly 2 cycles after the last byte is accepted (WAIT_GAP, then FIRE). busy_out returns to 0 afterwards.
- Back-to-back frames:
  - Stimulus: a second full frame immediately after the first.
  - Response: the second frame_rdy occurs ≥ 20 cycles after the first. busy_out stays 1 during the wait.
- Mid-load restart:
  - Stimulus: 10 bytes, then start asserted together with data_valid, then 24 bytes.
  - Response: the concurrent byte produces no strobe. Writes restart at layer 0, addr 0, lane 0001. abort_err_out=1. Exactly one frame_rdy.
- Start pending and backpressure:
  - Stimulus: start pulsed during WAIT_GAP.
  - Response: after FIRE, the block enters LOAD directly. data_valid held high in IDLE is never accepted.
- Async reset:
  - Stimulus: rst_in pulsed at byte 15.
  - Response: all outputs 0 within the reset cycle; the next start begins at layer 0, addr 0.
- AUTO_REFRESH_EN:
  - Defined: one frame loaded and idle → frame_rdy repeats every 100 cycles with no layer_en activity.
  - Undefined: no repeat occurs within 500 cycles.

Source files
------------

// File: rtl/layer_frame_sched.sv
// layer_frame_sched: frame scheduler in front of the per-layer LED output channels.
// Takes the host byte stream for one cube frame and turns each accepted byte into a
// one-cycle write strobe (layer one-hot, LED address, colour lane). Once the whole frame
// is in, it issues a single frame_rdy pulse, never closer than MIN_FRAME_GAP cycles to
// the previous one.
//
// Optional build macro LAYER_FRAME_SCHED_AUTO_REFRESH_EN: while idle, re-issue
// frame_rdy every REFRESH_PERIOD cycles with the stored frame (no writes).
module layer_frame_sched #(
  parameter int unsigned LAYER_CNT      = 8,
  parameter int unsigned LED_CNT        = 64,
  parameter int unsigned BYTES_PER_LED  = 3,
  parameter int unsigned MIN_FRAME_GAP  = 15000,
  parameter int unsigned REFRESH_PERIOD = 2500000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 frame_start_in,
  input  logic                 data_valid_in,
  input  logic [7:0]           data_in,
  output logic                 data_rdy_out,
  output logic [LAYER_CNT-1:0] layer_en_out,
  output logic [5:0]           wr_addr_out,
  output logic [3:0]           byte_sel_out,
  output logic [7:0]           byte_data_out,
  output logic                 frame_rdy_out,
  output logic                 busy_out,
  output logic                 abort_err_out
);

  localparam int unsigned     LayerW    = (LAYER_CNT > 1) ? $clog2(LAYER_CNT) : 1;
  localparam logic [LayerW-1:0] LastLayer = LayerW'(LAYER_CNT - 1);
  localparam logic [5:0]      LastLed   = 6'(LED_CNT - 1);
  localparam logic [1:0]      LastByte  = 2'(BYTES_PER_LED - 1);
  localparam logic [15:0]     GapMax    = 16'(MIN_FRAME_GAP);

  typedef enum logic [1:0] {StIdle, StLoad, StWaitGap, StFire} state_e;

  state_e              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [5:0]          led_q, led_d;
  logic [LayerW-1:0]   layer_q, layer_d;
  logic [15:0]         gap_q, gap_d;
  logic                pending_q, pending_d;
  logic                abort_q, abort_d;
  logic [LAYER_CNT-1:0] layer_en_q, layer_en_d;
  logic [5:0]          wr_addr_q, wr_addr_d;
  logic [3:0]          byte_sel_q, byte_sel_d;
  logic [7:0]          byte_data_q, byte_data_d;

  logic accept;
  logic clr_cnt;
  logic refresh_due;

`ifdef LAYER_FRAME_SCHED_AUTO_REFRESH_EN
  // Counter is loaded with 1 in FIRE, so leaving IDLE at REFRESH_PERIOD-2 lands the next
  // FIRE exactly REFRESH_PERIOD cycles after the previous one (WAIT_GAP + FIRE = 2 cycles).
  localparam int unsigned RefreshTrig = (REFRESH_PERIOD > 2) ? REFRESH_PERIOD - 2 : 0;

  logic [31:0] refresh_q, refresh_d;
  logic        frame_valid_q, frame_valid_d;

  // Refresh counter: cycles since the last frame_rdy, counted while idle.
  always_comb begin
    refresh_d     = refresh_q;
    frame_valid_d = frame_valid_q;
    if (state_q == StFire) begin
      refresh_d     = 32'd1;
      frame_valid_d = 1'b1;
    end else if (state_q == StIdle && refresh_q < RefreshTrig) begin
      refresh_d = refresh_q + 32'd1;
    end
  end

  // Only refresh once a frame has actually been latched into the layers.
  assign refresh_due = frame_valid_q && (refresh_q >= RefreshTrig);

  // Refresh state registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      refresh_q     <= 32'd0;
      frame_valid_q <= 1'b0;
    end else begin
      refresh_q     <= refresh_d;
      frame_valid_q <= frame_valid_d;
    end
  end
`else
  assign refresh_due = 1'b0;
`endif

  // Next-state logic: FSM transitions, byte/LED/layer counters, pending start, abort flag.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    led_d      = led_q;
    layer_d    = layer_q;
    pending_d  = pending_q;
    abort_d    = abort_q;
    accept     = 1'b0;
    clr_cnt    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A start arriving together with a refresh request wins.
        if (frame_start_in) begin
          state_d = StLoad;
          clr_cnt = 1'b1;
        end else if (refresh_due) begin
          state_d = StWaitGap;
        end
      end

      StLoad: begin
        if (frame_start_in) begin
          // Restart: any byte handshaken this cycle is dropped.
          clr_cnt = 1'b1;
          if (byte_idx_q != 2'd0 || led_q != 6'd0 || layer_q != '0) begin
            abort_d = 1'b1;
          end
        end else if (data_valid_in) begin
          accept = 1'b1;
          if (byte_idx_q == LastByte) begin
            byte_idx_d = 2'd0;
            if (led_q == LastLed) begin
              led_d = 6'd0;
              if (layer_q == LastLayer) begin
                state_d = StWaitGap;
              end else begin
                layer_d = layer_q + LayerW'(1);
              end
            end else begin
              led_d = led_q + 6'd1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      StWaitGap: begin
        if (frame_start_in) begin
          pending_d = 1'b1;
        end
        if (gap_q >= GapMax) begin
          state_d = StFire;
        end
      end

      StFire: begin
        // Starts seen during WAIT_GAP or FIRE collapse into one new load.
        if (pending_q || frame_start_in) begin
          state_d   = StLoad;
          clr_cnt   = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (clr_cnt) begin
      byte_idx_d = 2'd0;
      led_d      = 6'd0;
      layer_d    = '0;
    end
  end

  // Gap timer: cleared on each frame_rdy, then counts up and saturates at the minimum gap.
  always_comb begin
    if (state_q == StFire) begin
      gap_d = 16'd0;
    end else if (gap_q >= GapMax) begin
      gap_d = GapMax;
    end else begin
      gap_d = gap_q + 16'd1;
    end
  end

  // Write strobe for an accepted byte; address, lane and data hold between strobes.
  always_comb begin
    layer_en_d  = '0;
    wr_addr_d   = wr_addr_q;
    byte_sel_d  = byte_sel_q;
    byte_data_d = byte_data_q;
    if (accept) begin
      layer_en_d  = LAYER_CNT'(1) << layer_q;
      wr_addr_d   = led_q;
      byte_sel_d  = 4'd1 << byte_idx_q;
      byte_data_d = data_in;
    end
  end

  // State and datapath registers; reset also kills any in-flight strobe.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      byte_idx_q  <= 2'd0;
      led_q       <= 6'd0;
      layer_q     <= '0;
      gap_q       <= GapMax;
      pending_q   <= 1'b0;
      abort_q     <= 1'b0;
      layer_en_q  <= '0;
      wr_addr_q   <= 6'd0;
      byte_sel_q  <= 4'd0;
      byte_data_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      led_q       <= led_d;
      layer_q     <= layer_d;
      gap_q       <= gap_d;
      pending_q   <= pending_d;
      abort_q     <= abort_d;
      layer_en_q  <= layer_en_d;
      wr_addr_q   <= wr_addr_d;
      byte_sel_q  <= byte_sel_d;
      byte_data_q <= byte_data_d;
    end
  end

  // Decoded status outputs; data_rdy drops in the same cycle LOAD is left.
  always_comb begin
    data_rdy_out  = (state_q == StLoad);
    frame_rdy_out = (state_q == StFire);
    busy_out      = (state_q != StIdle);
    abort_err_out = abort_q;
    layer_en_out  = layer_en_q;
    wr_addr_out   = wr_addr_q;
    byte_sel_out  = byte_sel_q;
    byte_data_out = byte_data_q;
  end

endmodule

// File: tb/tb_layer_frame_sched.sv
// Directed testbench for layer_frame_sched (2 layers x 4 LEDs x 3 bytes, gap 20).
module tb_layer_frame_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] din = 8'd0;
  logic       data_rdy;
  logic [1:0] layer_en;
  logic [5:0] wr_addr;
  logic [3:0] byte_sel;
  logic [7:0] byte_data;
  logic       frame_rdy;
  logic       busy;
  logic       abort_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Strobe / frame_rdy capture
  logic [1:0] s_layer[0:255];
  logic [5:0] s_addr[0:255];
  logic [3:0] s_sel[0:255];
  logic [7:0] s_data[0:255];
  int         s_cyc[0:255];
  int         n_strobe = 0;
  int         rdy_cyc[0:15];
  int         n_rdy = 0;
  int         busy_low = 0;

  layer_frame_sched #(
    .LAYER_CNT      (2),
    .LED_CNT        (4),
    .BYTES_PER_LED  (3),
    .MIN_FRAME_GAP  (20),
    .REFRESH_PERIOD (100)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .frame_start_in (start),
    .data_valid_in  (dv),
    .data_in        (din),
    .data_rdy_out   (data_rdy),
    .layer_en_out   (layer_en),
    .wr_addr_out    (wr_addr),
    .byte_sel_out   (byte_sel),
    .byte_data_out  (byte_data),
    .frame_rdy_out  (frame_rdy),
    .busy_out       (busy),
    .abort_err_out  (abort_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (layer_en != 2'b00 && n_strobe < 256) begin
        s_layer[n_strobe] = layer_en;
        s_addr[n_strobe]  = wr_addr;
        s_sel[n_strobe]   = byte_sel;
        s_data[n_strobe]  = byte_data;
        s_cyc[n_strobe]   = cyc;
        n_strobe++;
      end
      if (frame_rdy && n_rdy < 16) begin
        rdy_cyc[n_rdy] = cyc;
        n_rdy++;
      end
      if (!busy) busy_low++;
    end
  end

  // Stimulus helpers: all start and end 1 time unit after a rising edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Drives n consecutive bytes; last_acc is the cycle in which the final byte was accepted.
  task automatic send_bytes(input int n, input int base, output int last_acc);
    last_acc = 0;
    for (int i = 0; i < n; i++) begin
      dv       = 1'b1;
      din      = 8'(base + i);
      last_acc = cyc;
      @(posedge clk);
      #1;
    end
    dv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({layer_en, wr_addr, byte_sel, byte_data, frame_rdy, busy, abort_err} !== 31'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {layer_en, wr_addr, byte_sel, byte_data, frame_rdy, busy, abort_err});
    end
    n_vec++;
    if (data_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data_rdy: got %b want 0", data_rdy);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    int b, r, last;
    logic [19:0] exp, got;
    b = n_strobe;
    r = n_rdy;
    pulse_start();
    n_vec++;
    if ({busy, data_rdy} !== 2'b11) begin
      n_err++;
      $display("FAIL ff_load_entry: got busy/rdy %b want 11", {busy, data_rdy});
    end
    send_bytes(24, 0, last);
    n_vec++;
    if (data_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL ff_rdy_drop: got %b want 0", data_rdy);
    end
    wait_cycles(4);
    n_vec++;
    if (n_strobe - b !== 24) begin
      n_err++;
      $display("FAIL ff_strobe_count: got %0d want 24", n_strobe - b);
    end
    for (int j = 0; j < 24; j++) begin
      exp = {(j < 12) ? 2'b01 : 2'b10, 6'((j % 12) / 3), 4'b0001 << (j % 3), 8'(j)};
      got = {s_layer[b+j], s_addr[b+j], s_sel[b+j], s_data[b+j]};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL ff_strobe[%0d]: got %h want %h", j, got, exp);
      end
    end
    n_vec++;
    if (s_cyc[b+23] !== last + 1) begin
      n_err++;
      $display("FAIL ff_write_latency: got cyc %0d want %0d", s_cyc[b+23], last + 1);
    end
    n_vec++;
    if (n_rdy - r !== 1) begin
      n_err++;
      $display("FAIL ff_rdy_count: got %0d want 1", n_rdy - r);
    end
    n_vec++;
    if (rdy_cyc[r] !== last + 2) begin
      n_err++;
      $display("FAIL ff_rdy_timing: got cyc %0d want %0d", rdy_cyc[r], last + 2);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ff_busy_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int b, r, bl, last_a, last_b;
    logic [19:0] got;
    b = n_strobe;
    r = n_rdy;
    pulse_start();
    bl = busy_low;
    send_bytes(24, 8'h20, last_a);
    pulse_start();            // lands in WAIT_GAP, becomes pending
    @(posedge clk);           // FIRE -> LOAD
    #1;
    n_vec++;
    if (data_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_pending_load: got data_rdy %b want 1", data_rdy);
    end
    send_bytes(24, 8'h60, last_b);
    n_vec++;
    if (busy_low - bl !== 0) begin
      n_err++;
      $display("FAIL b2b_busy_held: got %0d idle cycles want 0", busy_low - bl);
    end
    wait_cycles(4);
    n_vec++;
    if (n_rdy - r !== 2) begin
      n_err++;
      $display("FAIL b2b_rdy_count: got %0d want 2", n_rdy - r);
    end
    n_vec++;
    if (rdy_cyc[r] !== last_a + 2 || rdy_cyc[r+1] !== last_b + 2) begin
      n_err++;
      $display("FAIL b2b_rdy_timing: got %0d,%0d want %0d,%0d",
               rdy_cyc[r], rdy_cyc[r+1], last_a + 2, last_b + 2);
    end
    n_vec++;
    if (rdy_cyc[r+1] - rdy_cyc[r] < 20) begin
      n_err++;
      $display("FAIL b2b_min_gap: got %0d want >= 20", rdy_cyc[r+1] - rdy_cyc[r]);
    end
    n_vec++;
    if (n_strobe - b !== 48) begin
      n_err++;
      $display("FAIL b2b_strobe_count: got %0d want 48", n_strobe - b);
    end
    got = {s_layer[b+24], s_addr[b+24], s_sel[b+24], s_data[b+24]};
    n_vec++;
    if (got !== {2'b01, 6'd0, 4'b0001, 8'h60}) begin
      n_err++;
      $display("FAIL b2b_second_first: got %h want %h", got, {2'b01, 6'd0, 4'b0001, 8'h60});
    end
    got = {s_layer[b+47], s_addr[b+47], s_sel[b+47], s_data[b+47]};
    n_vec++;
    if (got !== {2'b10, 6'd3, 4'b0100, 8'h77}) begin
      n_err++;
      $display("FAIL b2b_second_last: got %h want %h", got, {2'b10, 6'd3, 4'b0100, 8'h77});
    end
  endtask

  task automatic test_backpressure();
    int b;
    b = n_strobe;
    dv  = 1'b1;
    din = 8'hAA;
    wait_cycles(10);
    n_vec++;
    if (n_strobe - b !== 0 || {busy, data_rdy} !== 2'b00) begin
      n_err++;
      $display("FAIL bp_idle_hold: got strobes %0d busy/rdy %b want 0 00",
               n_strobe - b, {busy, data_rdy});
    end
    start = 1'b1;             // start together with valid in IDLE
    @(posedge clk);
    #1;
    start = 1'b0;
    dv    = 1'b0;
    n_vec++;
    if (data_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL bp_start_taken: got data_rdy %b want 1", data_rdy);
    end
    wait_cycles(2);
    n_vec++;
    if (n_strobe - b !== 0) begin
      n_err++;
      $display("FAIL bp_no_write: got %0d strobes want 0", n_strobe - b);
    end
  endtask

  task automatic test_mid_load_restart();
    int b, r, last, hits;
    logic [19:0] exp, got;
    b = n_strobe;
    r = n_rdy;
    pulse_start();            // restart with nothing accepted yet
    n_vec++;
    if (abort_err !== 1'b0) begin
      n_err++;
      $display("FAIL ml_empty_restart_abort: got %b want 0", abort_err);
    end
    send_bytes(10, 8'h40, last);
    dv    = 1'b1;
    din   = 8'hEE;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_bytes(24, 8'h80, last);
    wait_cycles(4);
    n_vec++;
    if (n_strobe - b !== 34) begin
      n_err++;
      $display("FAIL ml_strobe_count: got %0d want 34", n_strobe - b);
    end
    got = {s_layer[b+9], s_addr[b+9], s_sel[b+9], s_data[b+9]};
    n_vec++;
    if (got !== {2'b01, 6'd3, 4'b0001, 8'h49}) begin
      n_err++;
      $display("FAIL ml_pre_abort: got %h want %h", got, {2'b01, 6'd3, 4'b0001, 8'h49});
    end
    hits = 0;
    for (int j = 0; j < 34; j++) if (s_data[b+j] == 8'hEE) hits++;
    n_vec++;
    if (hits !== 0) begin
      n_err++;
      $display("FAIL ml_concurrent_dropped: got %0d writes of EE want 0", hits);
    end
    for (int j = 0; j < 24; j++) begin
      exp = {(j < 12) ? 2'b01 : 2'b10, 6'((j % 12) / 3), 4'b0001 << (j % 3), 8'(8'h80 + j)};
      got = {s_layer[b+10+j], s_addr[b+10+j], s_sel[b+10+j], s_data[b+10+j]};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL ml_strobe[%0d]: got %h want %h", j, got, exp);
      end
    end
    n_vec++;
    if (abort_err !== 1'b1) begin
      n_err++;
      $display("FAIL ml_abort_flag: got %b want 1", abort_err);
    end
    n_vec++;
    if (n_rdy - r !== 1 || rdy_cyc[r] !== last + 2) begin
      n_err++;
      $display("FAIL ml_single_rdy: got %0d pulses at %0d want 1 at %0d",
               n_rdy - r, rdy_cyc[r], last + 2);
    end
  endtask

  task automatic test_async_reset();
    int b, r, last;
    logic [19:0] got;
    pulse_start();
    send_bytes(15, 8'h10, last);
    n_vec++;
    if ({layer_en, abort_err} !== 3'b101) begin
      n_err++;
      $display("FAIL ar_before: got layer_en/abort %b want 101", {layer_en, abort_err});
    end
    dv  = 1'b1;
    din = 8'h1F;
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({layer_en, wr_addr, byte_sel, byte_data, frame_rdy, busy, abort_err, data_rdy}
        !== 32'd0) begin
      n_err++;
      $display("FAIL ar_outputs: got %h want 0",
               {layer_en, wr_addr, byte_sel, byte_data, frame_rdy, busy, abort_err, data_rdy});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dv  = 1'b0;
    @(posedge clk);
    #1;
    b = n_strobe;
    r = n_rdy;
    pulse_start();
    send_bytes(24, 8'hC0, last);
    wait_cycles(4);
    got = {s_layer[b], s_addr[b], s_sel[b], s_data[b]};
    n_vec++;
    if (n_strobe - b !== 24 || got !== {2'b01, 6'd0, 4'b0001, 8'hC0}) begin
      n_err++;
      $display("FAIL ar_restart_first: got %0d strobes first %h want 24 %h",
               n_strobe - b, got, {2'b01, 6'd0, 4'b0001, 8'hC0});
    end
    n_vec++;
    if (n_rdy - r !== 1 || abort_err !== 1'b0) begin
      n_err++;
      $display("FAIL ar_frame_after: got rdy %0d abort %b want 1 0", n_rdy - r, abort_err);
    end
  endtask

  task automatic test_auto_refresh();
    int b, r;
    b = n_strobe;
    r = n_rdy;
    wait_cycles(500);
`ifdef LAYER_FRAME_SCHED_AUTO_REFRESH_EN
    n_vec++;
    if (n_rdy - r < 4) begin
      n_err++;
      $display("FAIL rf_repeat_count: got %0d want >= 4", n_rdy - r);
    end
    n_vec++;
    if (rdy_cyc[r+1] - rdy_cyc[r] !== 100) begin
      n_err++;
      $display("FAIL rf_period: got %0d want 100", rdy_cyc[r+1] - rdy_cyc[r]);
    end
`else
    n_vec++;
    if (n_rdy - r !== 0) begin
      n_err++;
      $display("FAIL rf_no_repeat: got %0d pulses want 0", n_rdy - r);
    end
`endif
    n_vec++;
    if (n_strobe - b !== 0) begin
      n_err++;
      $display("FAIL rf_no_writes: got %0d strobes want 0", n_strobe - b);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_backpressure();
    test_mid_load_restart();
    test_async_reset();
    test_auto_refresh();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
